test_cache: RTL and testbench



---
 rtl/test_cache_pkg.sv | 32 +++
 rtl/test_cache_pattern.sv | 21 ++
 rtl/test_cache.sv | 219 +++++++++++++++++++++
 tb/tb_test_cache.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_cache_pkg.sv
// Shared types and pattern helpers for the test_cache sequencer.
package test_cache_pkg;

  // Phase of a run.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_FWD,
    S_RD_REV,
    S_DONE
  } state_t;

  // Within a phase: ISSUE = request on the bus, WAIT = read accepted, awaiting data.
  typedef enum logic {
    SUB_ISSUE,
    SUB_WAIT
  } sub_t;

  localparam logic [31:0] PAT_MULT = 32'h0101_0101;

  // Word address of index i before truncation to the port width.
  function automatic logic [31:0] addr_of(input logic [31:0] i, input logic [31:0] base,
                                          input logic [31:0] stride);
    return base + i * stride;
  endfunction

  // Data word of index i before truncation to the port width.
  function automatic logic [31:0] data_of(input logic [31:0] i, input logic [31:0] seed);
    return seed ^ (i * PAT_MULT);
  endfunction

endpackage

// File: rtl/test_cache_pattern.sv
// Combinational index -> {address, data} map for the test pattern.
module test_cache_pattern
  import test_cache_pkg::*;
#(
  parameter int          ADDR_W    = 15,
  parameter int          DATA_W    = 32,
  parameter int          IDX_W     = 16,
  parameter int          BASE_ADDR = 0,
  parameter int          STRIDE    = 1,
  parameter logic [31:0] SEED      = 32'hA5A5_5A5A
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Truncation to ADDR_W gives the modulo-2^ADDR_W address wrap.
  assign addr = ADDR_W'(addr_of(32'(idx), 32'(BASE_ADDR), 32'(STRIDE)));
  assign data = DATA_W'(data_of(32'(idx), SEED));

endmodule

// File: rtl/test_cache.sv
// Built-in test sequencer for the cache CPU-side port: writes a pattern,
// reads it back forwards and in reverse, and reports pass/fail.
// Optional macro TEST_CACHE_LOG_EN adds simulation-only trace output.
module test_cache
  import test_cache_pkg::*;
#(
  parameter int          ADDR_W    = 15,
  parameter int          DATA_W    = 32,
  parameter int          NUM_WORDS = 64,
  parameter int          BASE_ADDR = 0,
  parameter int          STRIDE    = 1,
  parameter logic [31:0] SEED      = 32'hA5A5_5A5A,
  parameter int          TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic              req_valid,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              req_ready,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_rdata
);

  // One extra bit so NUM_WORDS = 2^ADDR_W still fits.
  localparam int              IDX_W     = ADDR_W + 1;
  localparam int              CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  state_t             state, state_nxt;
  sub_t               sub, sub_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               start_q;
  logic               start_edge;
  logic               valid_nxt, we_nxt, done_nxt, pass_nxt;
  logic [7:0]         err_nxt;
  logic               load, finish, abandon, mismatch, timeout;
  logic [ADDR_W-1:0]  pat_addr;
  logic [DATA_W-1:0]  pat_data;

  assign start_edge = start & ~start_q;

  // Pattern for the index about to be presented.
  test_cache_pattern #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W),
    .BASE_ADDR(BASE_ADDR),
    .STRIDE   (STRIDE),
    .SEED     (SEED)
  ) u_pattern (
    .idx (idx_nxt),
    .addr(pat_addr),
    .data(pat_data)
  );

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nxt = state;
    sub_nxt   = sub;
    idx_nxt   = idx;
    cnt_nxt   = cnt + CNT_W'(1);
    valid_nxt = req_valid;
    we_nxt    = req_we;
    done_nxt  = done;
    pass_nxt  = pass;
    err_nxt   = err_count;
    load      = 1'b0;
    finish    = 1'b0;
    abandon   = 1'b0;
    mismatch  = 1'b0;
    timeout   = 1'b0;

    if (state == S_IDLE || state == S_DONE) begin
      if (start_edge) begin
        state_nxt = S_WR;
        sub_nxt   = SUB_ISSUE;
        idx_nxt   = '0;
        cnt_nxt   = '0;
        valid_nxt = 1'b1;
        we_nxt    = 1'b1;
        load      = 1'b1;
        done_nxt  = 1'b0;
        pass_nxt  = 1'b0;
        err_nxt   = '0;
      end
    end else begin
      if (sub == SUB_ISSUE) begin
        if (!req_valid) begin
          // Re-present after an abandoned transaction left a one-cycle gap.
          valid_nxt = 1'b1;
          load      = 1'b1;
          cnt_nxt   = '0;
        end else if (req_ready) begin
          if (state == S_WR) begin
            finish = 1'b1;
          end else begin
            sub_nxt   = SUB_WAIT;
            valid_nxt = 1'b0;
            cnt_nxt   = '0;
          end
        end else if (cnt == CNT_LIMIT) begin
          timeout = 1'b1;
          finish  = 1'b1;
          abandon = 1'b1;
        end
      end else begin
        // req_wdata still holds data(idx) and doubles as the expected read value.
        if (resp_valid) begin
          finish   = 1'b1;
          mismatch = (resp_rdata != req_wdata);
        end else if (cnt == CNT_LIMIT) begin
          timeout = 1'b1;
          finish  = 1'b1;
          abandon = 1'b1;
        end
      end

      if ((mismatch || timeout) && err_count != 8'hFF) begin
        err_nxt = err_count + 8'd1;
      end

      if (finish) begin
        sub_nxt   = SUB_ISSUE;
        cnt_nxt   = '0;
        valid_nxt = !abandon;
        load      = !abandon;
        case (state)
          S_WR: begin
            if (idx == LAST_IDX) begin
              state_nxt = S_RD_FWD;
              idx_nxt   = '0;
              we_nxt    = 1'b0;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end
          S_RD_FWD: begin
            if (idx == LAST_IDX) begin
              state_nxt = S_RD_REV;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end
          default: begin
            if (idx == '0) begin
              state_nxt = S_DONE;
              valid_nxt = 1'b0;
              load      = 1'b0;
              done_nxt  = 1'b1;
              pass_nxt  = (err_nxt == 8'd0);
            end else begin
              idx_nxt = idx - IDX_W'(1);
            end
          end
        endcase
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every register here sees pre-edge values.
    if (reset) begin
      state     <= S_IDLE;
      sub       <= SUB_ISSUE;
      idx       <= '0;
      cnt       <= '0;
      // Treat start as already high so a level held through reset cannot launch a run.
      start_q   <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      req_valid <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else begin
      state     <= state_nxt;
      sub       <= sub_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      start_q   <= start;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_count <= err_nxt;
      req_valid <= valid_nxt;
      req_we    <= we_nxt;
      if (load) begin
        req_addr  <= pat_addr;
        req_wdata <= pat_data;
      end
    end
  end

`ifdef TEST_CACHE_LOG_EN
  // Simulation-only trace of failures and the final verdict.
  always_ff @(posedge clk) begin
    if (!reset && mismatch)
      $display("test_cache: read error idx=%0d addr=%0h exp=%0h got=%0h",
               idx, req_addr, req_wdata, resp_rdata);
    if (!reset && timeout)
      $display("test_cache: timeout idx=%0d addr=%0h", idx, req_addr);
    if (!reset && state != S_DONE && state_nxt == S_DONE)
      $display("test_cache: run complete, errors=%0d", err_nxt);
  end
`else
  // Default build carries no trace output.
`endif

endmodule

// File: tb/tb_test_cache.sv
// Bench for test_cache: a behavioural cache responder with stall/latency
// and fault injection, plus an ordered model of the expected request stream.
module tb_test_cache;

  localparam int          N      = 64;
  localparam int          BASE   = 240;
  localparam int          STRIDE = 3;
  localparam logic [31:0] SEED   = 32'hA5A5_5A5A;
  localparam int          TMO    = 24;
  localparam int          DROP_READ = 10;

  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic        done, pass;
  logic [7:0]  err_count;
  logic        req_valid, req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } acc_t;

  acc_t        acc_q[$];
  logic [31:0] mem [256];
  bit          rand_mode, flip_mode, drop_mode;
  bit          holding, rd_pending;
  int          stall_left, rd_wait, rd_count;
  logic [31:0] rd_data;
  logic        hold_we;
  logic [7:0]  hold_addr;
  logic [31:0] hold_data;

  test_cache #(
    .ADDR_W(8), .DATA_W(32), .NUM_WORDS(N), .BASE_ADDR(BASE),
    .STRIDE(STRIDE), .SEED(SEED), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .done(done), .pass(pass), .err_count(err_count),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] m_addr(input int i);
    return 8'((BASE + i * STRIDE) % 256);
  endfunction

  function automatic logic [31:0] m_data(input int i);
    return SEED ^ (i * 32'h0101_0101);
  endfunction

  // Mismatches between the accepted stream and the ideal order
  // (writes 0..N-1, reads 0..N-1, reads N-1..0).
  function automatic int seq_mismatches();
    int order[$];
    int bad = 0;
    for (int i = 0; i < N; i++) order.push_back(i);
    for (int i = 0; i < N; i++) order.push_back(i);
    for (int i = N - 1; i >= 0; i--) order.push_back(i);
    if (acc_q.size() != order.size()) return 1000 + acc_q.size();
    foreach (order[k]) begin
      if (acc_q[k].we !== (k < N) || acc_q[k].addr !== m_addr(order[k])) bad++;
      else if (k < N && acc_q[k].data !== m_data(order[k])) bad++;
    end
    return bad;
  endfunction

  // Cache-side responder: all decisions at the falling edge.
  initial begin
    req_ready = 0; resp_valid = 0; resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        holding = 0; rd_pending = 0; req_ready = 0; resp_valid = 0;
      end else begin
        resp_valid = 0;
        if (rd_pending) begin
          if (rd_wait == 0) begin
            resp_valid = 1; resp_rdata = rd_data; rd_pending = 0;
          end else rd_wait--;
        end else if (rand_mode) begin
          // Stray responses with nothing outstanding must be ignored.
          resp_valid = 1'($urandom_range(0, 1)); resp_rdata = $urandom;
        end
        req_ready = 0;
        if (req_valid) begin
          if (!holding) begin
            holding = 1; hold_we = req_we; hold_addr = req_addr; hold_data = req_wdata;
            stall_left = rand_mode ? $urandom_range(0, 7) : 0;
          end else begin
            checks++;
            if ({req_we, req_addr, req_wdata} !== {hold_we, hold_addr, hold_data}) begin
              errors++;
              $display("FAIL stable_fields got we=%0b addr=%0h data=%0h want we=%0b addr=%0h data=%0h",
                       req_we, req_addr, req_wdata, hold_we, hold_addr, hold_data);
            end
          end
          if (stall_left == 0) begin
            req_ready = 1; holding = 0;
            acc_q.push_back('{we: req_we, addr: req_addr, data: req_wdata, cyc: cyc + 1});
            if (req_we) mem[req_addr] = req_wdata;
            else begin
              rd_pending = !(drop_mode && rd_count == DROP_READ);
              rd_wait    = rand_mode ? $urandom_range(0, 19) : 0;
              rd_data    = mem[req_addr] ^ ((flip_mode && req_addr == m_addr(5)) ? 32'd1 : 32'd0);
              rd_count++;
            end
          end else stall_left--;
        end else holding = 0;
      end
    end
  end

  task automatic kick(input bit rnd, input bit flp, input bit drp, output int start_cyc);
    @(negedge clk);
    start = 0; rand_mode = rnd; flip_mode = flp; drop_mode = drp;
    acc_q.delete(); rd_count = 0;
    @(negedge clk);
    start = 1; start_cyc = cyc;
  endtask

  task automatic wait_done(input string name, output int done_cyc);
    bit ok = 0;
    done_cyc = -1;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1; done_cyc = cyc; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_done_timeout got done=%b want 1", name, done); end
  endtask

  task automatic test_reset();
    reset = 1; start = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({done, pass, err_count, req_valid, req_we, req_addr, req_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_values got done=%b pass=%b err=%0d valid=%b we=%b addr=%0h wdata=%0h want all 0",
               done, pass, err_count, req_valid, req_we, req_addr, req_wdata);
    end
    reset = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ideal();
    int sc, dc;
    kick(0, 0, 0, sc);
    @(negedge clk);
    checks++;
    if (req_valid !== 1 || req_we !== 1 || req_addr !== m_addr(0) || req_wdata !== m_data(0)) begin
      errors++;
      $display("FAIL ideal_first_req got v=%b we=%b addr=%0h data=%0h want 1 1 %0h %0h",
               req_valid, req_we, req_addr, req_wdata, m_addr(0), m_data(0));
    end
    wait_done("ideal", dc);
    checks++;
    if (pass !== 1 || err_count !== 0) begin
      errors++; $display("FAIL ideal_result got pass=%b err=%0d want 1 0", pass, err_count);
    end
    checks++;
    if (seq_mismatches() !== 0) begin
      errors++; $display("FAIL ideal_sequence got %0d bad entries (n=%0d) want 0", seq_mismatches(), acc_q.size());
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1 || pass !== 1 || req_valid !== 0) begin
      errors++; $display("FAIL ideal_hold got done=%b pass=%b valid=%b want 1 1 0", done, pass, req_valid);
    end
  endtask

  task automatic test_back_to_back();
    int sc, dc;
    kick(0, 0, 0, sc);
    @(negedge clk);
    checks++;
    if (done !== 0 || req_valid !== 1) begin
      errors++; $display("FAIL b2b_restart got done=%b valid=%b want 0 1", done, req_valid);
    end
    wait_done("b2b", dc);
    checks++;
    if (acc_q.size() != 3 * N) begin
      errors++; $display("FAIL b2b_count got %0d want %0d", acc_q.size(), 3 * N);
    end else begin
      checks++;
      if (acc_q[0].cyc !== sc + 2) begin
        errors++; $display("FAIL b2b_first_accept got %0d want %0d", acc_q[0].cyc, sc + 2);
      end
      checks++;
      if (acc_q[N - 1].cyc - acc_q[0].cyc !== N - 1) begin
        errors++; $display("FAIL b2b_write_span got %0d want %0d", acc_q[N - 1].cyc - acc_q[0].cyc, N - 1);
      end
      checks++;
      if (acc_q[3 * N - 1].cyc - acc_q[0].cyc !== 5 * N - 2) begin
        errors++; $display("FAIL b2b_total_span got %0d want %0d", acc_q[3 * N - 1].cyc - acc_q[0].cyc, 5 * N - 2);
      end
      checks++;
      if (dc !== acc_q[3 * N - 1].cyc + 1) begin
        errors++; $display("FAIL b2b_done_timing got %0d want %0d", dc, acc_q[3 * N - 1].cyc + 1);
      end
    end
  endtask

  task automatic test_mismatch();
    int sc, dc;
    kick(0, 1, 0, sc);
    wait_done("mismatch", dc);
    checks++;
    if (err_count !== 8'd2 || pass !== 0) begin
      errors++; $display("FAIL mismatch_result got err=%0d pass=%b want 2 0", err_count, pass);
    end
    checks++;
    if (seq_mismatches() !== 0) begin
      errors++; $display("FAIL mismatch_sequence got %0d bad entries want 0", seq_mismatches());
    end
  endtask

  task automatic test_rerun();
    int sc, dc;
    kick(0, 0, 0, sc);
    @(negedge clk);
    checks++;
    if (err_count !== 0 || done !== 0) begin
      errors++; $display("FAIL rerun_clear got err=%0d done=%b want 0 0", err_count, done);
    end
    wait_done("rerun", dc);
    checks++;
    if (pass !== 1 || err_count !== 0) begin
      errors++; $display("FAIL rerun_result got pass=%b err=%0d want 1 0", pass, err_count);
    end
  endtask

  task automatic test_random_stalls();
    int sc, dc;
    kick(1, 0, 0, sc);
    wait_done("random", dc);
    checks++;
    if (pass !== 1 || err_count !== 0) begin
      errors++; $display("FAIL random_result got pass=%b err=%0d want 1 0", pass, err_count);
    end
    checks++;
    if (seq_mismatches() !== 0) begin
      errors++; $display("FAIL random_sequence got %0d bad entries want 0", seq_mismatches());
    end
  endtask

  task automatic test_timeout();
    int sc, dc;
    kick(0, 0, 1, sc);
    wait_done("timeout", dc);
    checks++;
    if (err_count !== 8'd1 || pass !== 0 || done !== 1) begin
      errors++; $display("FAIL timeout_result got err=%0d pass=%b done=%b want 1 0 1", err_count, pass, done);
    end
    checks++;
    if (seq_mismatches() !== 0) begin
      errors++; $display("FAIL timeout_sequence got %0d bad entries want 0", seq_mismatches());
    end
  endtask

  task automatic test_mid_reset();
    int sc, dc;
    bit seen = 0;
    kick(0, 0, 0, sc);
    for (int c = 0; c < 2000 && acc_q.size() < N + 3; c++) @(negedge clk);
    checks++;
    if (acc_q.size() < N + 3) begin
      errors++; $display("FAIL midreset_reach got %0d accepts want >= %0d", acc_q.size(), N + 3);
    end
    reset = 1;
    @(negedge clk);
    checks++;
    if (req_valid !== 0 || done !== 0 || err_count !== 0 || pass !== 0) begin
      errors++; $display("FAIL midreset_outputs got valid=%b done=%b err=%0d pass=%b want 0 0 0 0",
                         req_valid, done, err_count, pass);
    end
    @(negedge clk);
    reset = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_valid === 1 || done === 1) seen = 1;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midreset_no_retrigger got activity=%b want 0", seen);
    end
    kick(0, 0, 0, sc);
    wait_done("midreset", dc);
    checks++;
    if (pass !== 1 || err_count !== 0 || seq_mismatches() !== 0) begin
      errors++; $display("FAIL midreset_rerun got pass=%b err=%0d bad=%0d want 1 0 0",
                         pass, err_count, seq_mismatches());
    end
  endtask

  initial begin
    rand_mode = 0; flip_mode = 0; drop_mode = 0;
    holding = 0; rd_pending = 0; rd_count = 0;
    test_reset();
    test_ideal();
    test_back_to_back();
    test_mismatch();
    test_rerun();
    test_random_stalls();
    test_timeout();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
